// File: rtl/mem_stage_hs.sv
// RV32 memory stage with a variable-latency req/ack data port.
// Optional ack watchdog: define MEM_ACK_TIMEOUT_EN.
module mem_stage_hs #(
    parameter int XLEN        = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_vld,
    output logic            o_rdy,
    input  logic [XLEN-1:0] i_pc,
    input  logic [31:0]     i_inst,
    input  logic [XLEN-1:0] i_alu_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic            i_lsu_rden,
    input  logic            i_lsu_wren,
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_wb_sel,
    input  logic            i_rd_wren,
    output logic            o_dmem_req,
    output logic            o_dmem_we,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic [XLEN-1:0] o_dmem_wdata,
    output logic [3:0]      o_dmem_be,
    input  logic            i_dmem_ack,
    input  logic [XLEN-1:0] i_dmem_rdata,
    output logic            o_wb_vld,
    output logic [XLEN-1:0] o_wb_pc_add4,
    output logic [XLEN-1:0] o_wb_pc,
    output logic [XLEN-1:0] o_wb_alu_data,
    output logic [XLEN-1:0] o_wb_ld_data,
    output logic [31:0]     o_wb_inst,
    output logic [1:0]      o_wb_sel,
    output logic            o_wb_rd_wren,
    output logic [4:0]      o_fwd_rd_addr,
    output logic            o_misalign,
    output logic            o_timeout
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_REQ  = 1'b1;

    logic [0:0]      state;
    logic [XLEN-1:0] p_pc;
    logic [XLEN-1:0] p_alu;
    logic [31:0]     p_inst;
    logic [2:0]      p_funct3;
    logic [1:0]      p_wb_sel;
    logic            p_rd_wren;
    logic            p_load;

    logic            accept;
    logic            memop;
    logic            mis;
    logic            mis_acc;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] ld_ext;
    logic            to_hit;

    assign o_rdy         = (state == S_IDLE);
    assign accept        = i_vld & o_rdy;
    assign memop         = i_lsu_rden | i_lsu_wren;
    assign mis_acc       = memop & mis;
    assign o_fwd_rd_addr = (state == S_REQ) ? p_inst[11:7] : i_inst[11:7];

    // Size decode: alignment check, byte enables and lane-replicated store data
    always_comb begin
        mis   = 1'b0;
        be    = 4'b1111;
        wdata = i_rs2_data;
        case (i_funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << i_alu_data[1:0];
                wdata = {4{i_rs2_data[7:0]}};
            end
            2'b01: begin
                mis   = i_alu_data[0];
                be    = i_alu_data[1] ? 4'b1100 : 4'b0011;
                wdata = {2{i_rs2_data[15:0]}};
            end
            default: mis = |i_alu_data[1:0];
        endcase
    end

    // Load lane select and sign/zero extension of the returned word
    always_comb begin
        shifted = i_dmem_rdata >> {p_alu[1:0], 3'b000};
        case (p_funct3)
            3'b000:  ld_ext = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            3'b001:  ld_ext = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'b100:  ld_ext = {{(XLEN-8){1'b0}}, shifted[7:0]};
            3'b101:  ld_ext = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: ld_ext = i_dmem_rdata;
        endcase
    end

`ifdef MEM_ACK_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    assign to_hit = (state == S_REQ) & ~i_dmem_ack & (cnt == TO_LAST);

    // Watchdog: counts REQ cycles, cleared whenever the stage is idle
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt       <= '0;
            o_timeout <= 1'b0;
        end else begin
            cnt       <= (state == S_REQ) ? cnt + 1'b1 : '0;
            o_timeout <= to_hit;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = |TIMEOUT_CYC;
    assign to_hit     = 1'b0;
    assign o_timeout  = 1'b0;
`endif

    // Stage FSM, memory request registers and writeback bundle
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= S_IDLE;
            o_dmem_req    <= 1'b0;
            o_dmem_we     <= 1'b0;
            o_dmem_addr   <= '0;
            o_dmem_wdata  <= '0;
            o_dmem_be     <= '0;
            o_wb_vld      <= 1'b0;
            o_wb_pc_add4  <= '0;
            o_wb_pc       <= '0;
            o_wb_alu_data <= '0;
            o_wb_ld_data  <= '0;
            o_wb_inst     <= '0;
            o_wb_sel      <= '0;
            o_wb_rd_wren  <= 1'b0;
            o_misalign    <= 1'b0;
            p_pc          <= '0;
            p_alu         <= '0;
            p_inst        <= '0;
            p_funct3      <= '0;
            p_wb_sel      <= '0;
            p_rd_wren     <= 1'b0;
            p_load        <= 1'b0;
        end else begin
            o_wb_vld   <= 1'b0;
            o_misalign <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept && memop && !mis) begin
                        state        <= S_REQ;
                        o_dmem_req   <= 1'b1;
                        o_dmem_we    <= i_lsu_wren;
                        o_dmem_addr  <= {i_alu_data[XLEN-1:2], 2'b00};
                        o_dmem_be    <= be;
                        o_dmem_wdata <= wdata;
                        p_pc         <= i_pc;
                        p_alu        <= i_alu_data;
                        p_inst       <= i_inst;
                        p_funct3     <= i_funct3;
                        p_wb_sel     <= i_wb_sel;
                        p_rd_wren    <= i_rd_wren;
                        p_load       <= i_lsu_rden & ~i_lsu_wren;
                    end else if (accept) begin
                        o_wb_vld      <= 1'b1;
                        o_wb_pc_add4  <= i_pc + XLEN'(4);
                        o_wb_pc       <= i_pc;
                        o_wb_alu_data <= i_alu_data;
                        o_wb_ld_data  <= '0;
                        o_wb_inst     <= i_inst;
                        o_wb_sel      <= i_wb_sel;
                        o_wb_rd_wren  <= i_rd_wren & ~mis_acc;
                        o_misalign    <= mis_acc;
                    end
                end
                S_REQ: begin
                    if (i_dmem_ack || to_hit) begin
                        state         <= S_IDLE;
                        o_dmem_req    <= 1'b0;
                        o_dmem_we     <= 1'b0;
                        o_wb_vld      <= 1'b1;
                        o_wb_pc_add4  <= p_pc + XLEN'(4);
                        o_wb_pc       <= p_pc;
                        o_wb_alu_data <= p_alu;
                        o_wb_ld_data  <= (p_load && i_dmem_ack) ? ld_ext : '0;
                        o_wb_inst     <= p_inst;
                        o_wb_sel      <= p_wb_sel;
                        o_wb_rd_wren  <= p_rd_wren & ~to_hit;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_hs.sv
// Randomized self-checking bench for mem_stage_hs.
// Reference model computes expectations from access-size arithmetic.
module tb_mem_stage_hs;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld;
    logic        rdy;
    logic [31:0] pc, inst, alu, rs2;
    logic        rden, wren;
    logic [2:0]  f3;
    logic [1:0]  sel;
    logic        rdw;
    logic        req, we;
    logic [31:0] addr, wdat;
    logic [3:0]  be;
    logic        ack;
    logic [31:0] rdata;
    logic        wb_vld;
    logic [31:0] wb_add4, wb_pc, wb_alu, wb_ld, wb_inst;
    logic [1:0]  wb_sel;
    logic        wb_rdw;
    logic [4:0]  fwd;
    logic        misal, tmo;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_stage_hs #(.XLEN(32), .TIMEOUT_CYC(TO)) dut (
        .i_clk(clk), .i_reset(rst), .i_vld(vld), .o_rdy(rdy),
        .i_pc(pc), .i_inst(inst), .i_alu_data(alu), .i_rs2_data(rs2),
        .i_lsu_rden(rden), .i_lsu_wren(wren), .i_funct3(f3),
        .i_wb_sel(sel), .i_rd_wren(rdw),
        .o_dmem_req(req), .o_dmem_we(we), .o_dmem_addr(addr),
        .o_dmem_wdata(wdat), .o_dmem_be(be),
        .i_dmem_ack(ack), .i_dmem_rdata(rdata),
        .o_wb_vld(wb_vld), .o_wb_pc_add4(wb_add4), .o_wb_pc(wb_pc),
        .o_wb_alu_data(wb_alu), .o_wb_ld_data(wb_ld), .o_wb_inst(wb_inst),
        .o_wb_sel(wb_sel), .o_wb_rd_wren(wb_rdw), .o_fwd_rd_addr(fwd),
        .o_misalign(misal), .o_timeout(tmo)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic int sz(input logic [2:0] f);
        if (f[1:0] == 2'b00) return 1;
        if (f[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic is_mis(input logic [2:0] f, input logic [31:0] a);
        return (a % sz(f)) != 0;
    endfunction

    function automatic logic [31:0] exp_ld(input logic [2:0] f,
                                           input logic [31:0] a,
                                           input logic [31:0] d);
        int s;
        logic [31:0] v, mask;
        s = sz(f);
        v = d >> (8 * (a % 4));
        mask = (s == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * s)) - 1;
        v = v & mask;
        if (s < 4 && !f[2] && v[8*s-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] exp_be(input logic [2:0] f,
                                           input logic [31:0] a);
        int s;
        s = sz(f);
        return (((32'h1 << s) - 1) << (a % 4)) & 32'hF;
    endfunction

    function automatic logic [31:0] exp_wd(input logic [2:0] f,
                                           input logic [31:0] d);
        int s;
        s = sz(f);
        if (s == 1) return {24'h0, d[7:0]} * 32'h0101_0101;
        if (s == 2) return {16'h0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    task automatic scramble();
        vld  = 1'b0;
        pc   = $urandom;
        inst = $urandom;
        alu  = $urandom;
        rs2  = $urandom;
        f3   = 3'($urandom);
        rden = 1'($urandom);
        wren = 1'($urandom);
        sel  = 2'($urandom);
        rdw  = 1'($urandom);
    endtask

    task automatic chk_wb(input string t, input logic [31:0] p,
                          input logic [31:0] in, input logic [31:0] a,
                          input logic [1:0] s, input logic r,
                          input logic [31:0] ld, input logic m,
                          input logic tm);
        chk({t, "_vld"}, wb_vld, 1);
        chk({t, "_add4"}, wb_add4, p + 32'd4);
        chk({t, "_pc"}, wb_pc, p);
        chk({t, "_alu"}, wb_alu, a);
        chk({t, "_inst"}, wb_inst, in);
        chk({t, "_sel"}, wb_sel, s);
        chk({t, "_rdw"}, wb_rdw, r);
        chk({t, "_ld"}, wb_ld, ld);
        chk({t, "_mis"}, misal, m);
        chk({t, "_tmo"}, tmo, tm);
    endtask

    // One instruction through the stage; delay = REQ cycles before ack
    task automatic run_op(input string t, input logic [31:0] p,
                          input logic [31:0] in, input logic [31:0] a,
                          input logic [31:0] d, input logic rd,
                          input logic wr, input logic [2:0] f,
                          input logic [1:0] s, input logic r,
                          input int delay, input logic [31:0] rv);
        logic memop, m, ld_op;
        memop = rd | wr;
        m     = memop && is_mis(f, a);
        ld_op = rd && !wr;
        chk({t, "_rdy0"}, rdy, 1);
        vld = 1'b1; pc = p; inst = in; alu = a; rs2 = d;
        rden = rd; wren = wr; f3 = f; sel = s; rdw = r; ack = 1'b0;
        @(negedge clk);
        scramble();
        if (!memop || m) begin
            chk({t, "_noreq"}, req, 0);
            chk_wb(t, p, in, a, s, r && !m, 32'h0, m, 1'b0);
        end else begin
            chk({t, "_req"}, req, 1);
            chk({t, "_we"}, we, wr);
            chk({t, "_addr"}, addr, a & 32'hFFFF_FFFC);
            chk({t, "_be"}, be, exp_be(f, a));
            if (wr) chk({t, "_wd"}, wdat, exp_wd(f, d));
            chk({t, "_rdyl"}, rdy, 0);
            chk({t, "_fwd"}, fwd, in[11:7]);
            for (int k = 0; k < delay; k++) begin
                @(negedge clk);
                chk({t, "_wait"}, {req, rdy, wb_vld}, 3'b100);
                chk({t, "_hold"}, addr, a & 32'hFFFF_FFFC);
            end
            ack = 1'b1; rdata = rv;
            @(negedge clk);
            ack = 1'b0; rdata = $urandom;
            chk({t, "_done"}, {req, rdy}, 2'b01);
            chk_wb(t, p, in, a, s, r, ld_op ? exp_ld(f, a, rv) : 32'h0,
                   1'b0, 1'b0);
        end
        @(negedge clk);
        chk({t, "_idle"}, wb_vld, 0);
        chk({t, "_keep"}, wb_alu, a);
    endtask

    initial begin
        logic [31:0] a, p;
        logic rd, wr;
        logic [2:0] f;
        scramble();
        ack = 1'b0; rdata = '0; rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_state", {wb_vld, req, we, misal, tmo, rdy}, 6'b000001);
        chk("rst_addr", addr, 0);
        chk("rst_wd", wdat, 0);
        chk("rst_be", be, 0);
        chk("rst_wb", wb_alu | wb_pc | wb_ld | wb_inst, 0);

        run_op("alu", 32'h100, 32'h0000_0593, 32'h55, 0, 0, 0, 3'b000,
               2'b01, 1, 0, 0);
        run_op("lb", 32'h200, 32'h0000_0283, 32'h203, 0, 1, 0, 3'b000,
               2'b10, 1, 2, 32'h80FF_FF00);
        run_op("lhu", 32'h204, 32'h0000_5303, 32'h202, 0, 1, 0, 3'b101,
               2'b10, 1, 0, 32'hBEEF_1234);
        run_op("sb", 32'h208, 32'h0000_00A3, 32'h101, 32'hAB, 0, 1,
               3'b000, 2'b00, 1, 1, 32'h0);
        run_op("lw_mis", 32'h20C, 32'h0000_2383, 32'h102, 0, 1, 0,
               3'b010, 2'b10, 1, 0, 0);
        run_op("wrap", 32'hFFFF_FFFC, 32'h13, 32'h7, 0, 0, 0, 3'b000,
               2'b01, 1, 0, 0);
        run_op("rdwr", 32'h300, 32'h0000_2023, 32'h400, 32'h1234_5678,
               1, 1, 3'b010, 2'b00, 0, 1, 32'hFFFF_FFFF);

        ack = 1'b1; rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        ack = 1'b0;
        chk("ack_idle", {wb_vld, req, rdy}, 3'b001);

        vld = 1'b1; pc = 32'h40; inst = 32'h111; alu = 32'hA1;
        rden = 0; wren = 0; rdw = 1; sel = 2'b01;
        @(negedge clk);
        chk("b2b_a", wb_alu, 32'hA1);
        chk("b2b_av", {wb_vld, rdy}, 2'b11);
        pc = 32'h44; inst = 32'h222; alu = 32'hB2;
        @(negedge clk);
        vld = 1'b0;
        chk("b2b_b", wb_alu, 32'hB2);
        chk("b2b_bpc", wb_add4, 32'h48);
        chk("b2b_bv", wb_vld, 1);
        @(negedge clk);

        vld = 1'b1; pc = 32'h50; inst = 32'h2083; alu = 32'h800;
        rden = 1; wren = 0; f3 = 3'b010;
        @(negedge clk);
        scramble();
        chk("rst_req_a", req, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_req_b", {req, wb_vld, rdy}, 3'b001);
        @(negedge clk);
        chk("rst_req_c", {req, wb_vld}, 2'b00);

`ifdef MEM_ACK_TIMEOUT_EN
        vld = 1'b1; pc = 32'h60; inst = 32'h0000_2503; alu = 32'h900;
        rden = 1; wren = 0; f3 = 3'b010; rdw = 1; sel = 2'b10;
        @(negedge clk);
        vld = 1'b0;
        for (int k = 0; k < TO; k++) begin
            chk("to_req", {req, rdy}, 2'b10);
            @(negedge clk);
        end
        chk("to_done", {req, rdy, tmo, wb_vld, wb_rdw}, 5'b01110);
        chk("to_pc", wb_pc, 32'h60);
        @(negedge clk);
        chk("to_pulse", tmo, 0);
`endif

        for (int i = 0; i < 150; i++) begin
            p  = $urandom & 32'hFFFF_FFFC;
            a  = $urandom;
            rd = 1'($urandom);
            wr = 1'($urandom);
            f  = 3'($urandom);
            if (wr) f[2] = 1'b0;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            run_op("rnd", p, $urandom, a, $urandom, rd, wr, f,
                   2'($urandom), 1'($urandom), $urandom_range(0, TO - 1),
                   $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
